// File: rtl/seg_scan_controller.sv
// -----------------------------------------------------------------------------
// seg_scan_controller
//
// Time-multiplexing scan controller for a 4-digit common-anode seven-segment
// display. It holds a 16-bit display value and presents one nibble at a time
// on bin (feeding the binary_segment decoder). It also drives the matching
// active-low anode. Each digit slot starts with a dead-time in which all
// anodes are off, so the decoder output settles before a digit lights and
// no ghosting occurs. New values are double-buffered and only become active
// at a frame boundary, so a single frame never mixes old and new digits.
//
// Parameters
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//   DEAD_CYCLES  cycles of all-anodes-off at the start of each slot
//                (0 <= DEAD_CYCLES < REFRESH_DIV)
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   load        in   capture value_in / blank_in / dp_in this cycle
//   value_in    in   16  four hex digits, digit i = value_in[4i+3:4i]
//   blank_in    in   4   per-digit blank mask, 1 = digit dark
//   dp_in       in   4   per-digit decimal point, 1 = lit
//   bin         out  4   nibble for binary_segment.bin
//   an          out  4   active-low anodes, an[i] = digit i
//   dp          out  1   active-low decimal point
//   pending     out  1   a loaded value waits for the frame boundary
//   frame_tick  out  1   pulse on the last cycle of digit 3's slot
// -----------------------------------------------------------------------------
module seg_scan_controller #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  blank_in,
    input  logic [3:0]  dp_in,
    output logic [3:0]  bin,
    output logic [3:0]  an,
    output logic        dp,
    output logic        pending,
    output logic        frame_tick
);

    // Smallest counter that can hold REFRESH_DIV-1.
    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_SHOW = 1'b1
    } state_e;

    // With no dead-time, a slot begins directly in SHOW.
    localparam state_e ST_START = (DEAD_CYCLES > 0) ? ST_DEAD : ST_SHOW;

    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [1:0]       idx_q,        idx_d;
    state_e           state_q,      state_d;
    logic [15:0]      act_val_q,    act_val_d;
    logic [3:0]       act_blank_q,  act_blank_d;
    logic [3:0]       act_dp_q,     act_dp_d;
    logic [15:0]      pend_val_q,   pend_val_d;
    logic [3:0]       pend_blank_q, pend_blank_d;
    logic [3:0]       pend_dp_q,    pend_dp_d;
    logic             pending_q,    pending_d;

    logic             frame_end;
    logic             lit;

    assign frame_end = (cnt_q == CNT_LAST) && (idx_q == 2'd3);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            state_q      <= ST_START;
            act_val_q    <= 16'h0000;
            act_blank_q  <= 4'b1111;
            act_dp_q     <= 4'b0000;
            pend_val_q   <= 16'h0000;
            pend_blank_q <= 4'b1111;
            pend_dp_q    <= 4'b0000;
            pending_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            act_val_q    <= act_val_d;
            act_blank_q  <= act_blank_d;
            act_dp_q     <= act_dp_d;
            pend_val_q   <= pend_val_d;
            pend_blank_q <= pend_blank_d;
            pend_dp_q    <= pend_dp_d;
            pending_q    <= pending_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        state_d      = state_q;
        act_val_d    = act_val_q;
        act_blank_d  = act_blank_q;
        act_dp_d     = act_dp_q;
        pend_val_d   = pend_val_q;
        pend_blank_d = pend_blank_q;
        pend_dp_d    = pend_dp_q;
        pending_d    = pending_q;

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        // The slot state is registered from the next count so the output
        // decode below only sees flops.
        if ((DEAD_CYCLES > 0) && (32'(cnt_d) < 32'(DEAD_CYCLES))) begin
            state_d = ST_DEAD;
        end else begin
            state_d = ST_SHOW;
        end

        if (load && frame_end) begin
            // Landing exactly on the boundary: go straight to the active set
            // and drop whatever was waiting.
            act_val_d   = value_in;
            act_blank_d = blank_in;
            act_dp_d    = dp_in;
            pending_d   = 1'b0;
        end else if (load) begin
            pend_val_d   = value_in;
            pend_blank_d = blank_in;
            pend_dp_d    = dp_in;
            pending_d    = 1'b1;
        end else if (frame_end && pending_q) begin
            act_val_d   = pend_val_q;
            act_blank_d = pend_blank_q;
            act_dp_d    = pend_dp_q;
            pending_d   = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode (registers only)
    // -------------------------------------------------------------------------
    assign lit = (state_q == ST_SHOW) && !act_blank_q[idx_q];

    always_comb begin
        bin        = act_val_q[{idx_q, 2'b00} +: 4];
        an         = 4'b1111;
        dp         = 1'b1;
        pending    = pending_q;
        frame_tick = frame_end;
        if (lit) begin
            an[idx_q] = 1'b0;
            dp        = ~act_dp_q[idx_q];
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_controller
//
// Bench for seg_scan_controller with REFRESH_DIV = 8 and DEAD_CYCLES = 2
// (32-cycle frame). For every cycle it expects, the bench pushes the
// required outputs into a scoreboard queue. Each scenario task then
// drives its loads and resets and pops the queue. It compares one entry
// per cycle.
// -----------------------------------------------------------------------------
module tb_seg_scan_controller;

    localparam int RDIV  = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = 4 * RDIV;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  blank_in;
    logic [3:0]  dp_in;
    logic [3:0]  bin;
    logic [3:0]  an;
    logic        dp;
    logic        pending;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;
    int frame_no = 0;

    typedef struct {
        logic [3:0] an;
        logic       dp;
        logic [3:0] bin;
        logic       ft;
        logic       pend;
    } exp_t;

    exp_t sb[$];

    seg_scan_controller #(
        .REFRESH_DIV (RDIV),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .value_in   (value_in),
        .blank_in   (blank_in),
        .dp_in      (dp_in),
        .bin        (bin),
        .an         (an),
        .dp         (dp),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Expected outputs for the first n cycles of a frame showing value v with
    // blank mask bl and dp mask dpm; pending expected high for frame cycles
    // pend_lo..pend_hi.
    function automatic void push_frame(input logic [15:0] v, input logic [3:0] bl,
                                       input logic [3:0] dpm, input int pend_lo,
                                       input int pend_hi, input int n);
        exp_t e;
        logic [15:0] vv;
        vv = v;
        for (int p = 0; p < n; p++) begin
            int  slot;
            int  c;
            logic show;
            slot   = p / RDIV;
            c      = p % RDIV;
            show   = (c >= DEAD) && !bl[slot];
            e.bin  = vv[slot*4 +: 4];
            e.an   = show ? ~(4'b0001 << slot) : 4'b1111;
            e.dp   = show ? ~dpm[slot] : 1'b1;
            e.ft   = (p == FRAME - 1);
            e.pend = (p >= pend_lo) && (p <= pend_hi);
            sb.push_back(e);
        end
    endfunction

    // Runs n cycles of a frame, comparing each cycle against the scoreboard.
    // Optional loads at cycles ld_a (value va) and ld_b (value vb), both with
    // blank mask ba and dp mask da; optional reset pulse at cycle rst_at.
    // Loads and resets are driven in the cycle named and sampled at its end.
    task automatic run_frame(input int n, input int ld_a, input logic [15:0] va,
                             input int ld_b, input logic [15:0] vb,
                             input logic [3:0] ba, input logic [3:0] da,
                             input int rst_at);
        exp_t e;
        int   bad;
        bad = 0;
        for (int p = 0; p < n; p++) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                bad++;
                $display("FAIL scoreboard_empty frame=%0d cyc=%0d actual=empty required=entry",
                         frame_no, p);
            end else begin
                e = sb.pop_front();
                if ({an, dp, bin, frame_tick, pending} !== {e.an, e.dp, e.bin, e.ft, e.pend}) begin
                    failures++;
                    bad++;
                    $display("FAIL scan frame=%0d cyc=%0d actual an=%b dp=%b bin=%h ft=%b pend=%b required an=%b dp=%b bin=%h ft=%b pend=%b",
                             frame_no, p, an, dp, bin, frame_tick, pending,
                             e.an, e.dp, e.bin, e.ft, e.pend);
                end
            end
            load     = (p == ld_a) || (p == ld_b);
            value_in = (p == ld_b) ? vb : va;
            blank_in = ba;
            dp_in    = da;
            reset    = (p == rst_at);
            @(posedge clk);
            #1;
            load = 1'b0;
            if (p == rst_at) begin
                reset = 1'b0;
                break;
            end
        end
        $display("frame %0d: %0d cycles, %0d bad", frame_no, n, bad);
        frame_no++;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        load     = 1'b0;
        value_in = 16'h0;
        blank_in = 4'h0;
        dp_in    = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({an, dp, bin, frame_tick, pending} !== {4'b1111, 1'b1, 4'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs actual an=%b dp=%b bin=%h ft=%b pend=%b required an=1111 dp=1 bin=0 ft=0 pend=0",
                     an, dp, bin, frame_tick, pending);
        end
        reset = 1'b0;
        // Dark frame after release: all anodes off, frame_tick only at 31.
        push_frame(16'h0000, 4'b1111, 4'b0000, -1, -1, FRAME);
        run_frame(FRAME, -1, 16'h0, -1, 16'h0, 4'h0, 4'h0, -1);
    endtask

    task automatic test_load_display();
        push_frame(16'h0000, 4'b1111, 4'b0000, 6, 31, FRAME);
        run_frame(FRAME, 5, 16'h4321, -1, 16'h0, 4'b0000, 4'b0100, -1);
        push_frame(16'h4321, 4'b0000, 4'b0100, -1, -1, FRAME);
        run_frame(FRAME, -1, 16'h0, -1, 16'h0, 4'h0, 4'h0, -1);
    endtask

    task automatic test_back_to_back();
        push_frame(16'h4321, 4'b0000, 4'b0100, 4, 31, FRAME);
        run_frame(FRAME, 3, 16'hAAAA, 20, 16'h5555, 4'b0000, 4'b0000, -1);
        push_frame(16'h5555, 4'b0000, 4'b0000, -1, -1, FRAME);
        run_frame(FRAME, -1, 16'h0, -1, 16'h0, 4'h0, 4'h0, -1);
    endtask

    task automatic test_frame_end_load();
        // Load on the frame_tick cycle; pending never rises.
        push_frame(16'h5555, 4'b0000, 4'b0000, -1, -1, FRAME);
        run_frame(FRAME, FRAME - 1, 16'hBEEF, -1, 16'h0, 4'b0000, 4'b0000, -1);
    endtask

    task automatic test_blank_mask();
        push_frame(16'hBEEF, 4'b0000, 4'b0000, -1, -1, FRAME);
        run_frame(FRAME, FRAME - 1, 16'h9876, -1, 16'h0, 4'b1010, 4'b1111, -1);
        push_frame(16'h9876, 4'b1010, 4'b1111, -1, -1, FRAME);
        run_frame(FRAME, -1, 16'h0, -1, 16'h0, 4'h0, 4'h0, -1);
    endtask

    task automatic test_reset_midframe();
        // Load 7777 at cycle 2, reset at cycle 20 (digit 2 SHOW, lit).
        push_frame(16'h9876, 4'b1010, 4'b1111, 3, 20, 21);
        run_frame(21, 2, 16'h7777, -1, 16'h0, 4'b0000, 4'b0000, 20);
        // After reset: two dark frames; the discarded 7777 never appears.
        push_frame(16'h0000, 4'b1111, 4'b0000, -1, -1, FRAME);
        push_frame(16'h0000, 4'b1111, 4'b0000, -1, -1, FRAME);
        run_frame(FRAME, -1, 16'h0, -1, 16'h0, 4'h0, 4'h0, -1);
        run_frame(FRAME, -1, 16'h0, -1, 16'h0, 4'h0, 4'h0, -1);
    endtask

    initial begin
        test_reset();
        test_load_display();
        test_back_to_back();
        test_frame_end_load();
        test_blank_mask();
        test_reset_midframe();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
